// File: rtl/hart_mem_arbiter_pkg.sv
`default_nettype none
// ============================================================================
// Module      : hart_mem_arbiter_pkg
// Description : Shared types and constants for the hart-to-DRAM arbiter.
//               Holds the arbiter state encoding, the default hart count and
//               the width of the size/sign control field. The control field
//               encoding is the DRAM controller's own and passes through
//               unchanged.
// Revision    : 1.0 - initial release
// ============================================================================
package hart_mem_arbiter_pkg;

  localparam int NHART_DEFAULT = 2;
  localparam int CTRL_W        = 3;

  typedef enum logic [1:0] {
    ARB_IDLE  = 2'd0,
    ARB_ISSUE = 2'd1,
    ARB_WAIT  = 2'd2
  } arb_state_e;

endpackage
`default_nettype wire

// File: rtl/hart_mem_arbiter_rr_pick.sv
`default_nettype none
// ============================================================================
// Module      : hart_mem_arbiter_rr_pick
// Description : Combinational round-robin finder. Returns the first set bit
//               of i_vec at or after position (i_last+1) mod N, wrapping.
// Ports       : i_vec  - candidate vector
//               i_last - index granted most recently
//               o_idx  - selected index (valid when o_hit)
//               o_hit  - at least one candidate bit is set
// Revision    : 1.0 - initial release
// ============================================================================
module hart_mem_arbiter_rr_pick #(
  parameter int N  = 2,
  parameter int IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  i_vec,
  input  logic [IW-1:0] i_last,
  output logic [IW-1:0] o_idx,
  output logic          o_hit
);

  logic [IW-1:0] w_pos;

  // Scan from the farthest position (i_last itself, k = N) down to the
  // nearest (k = 1); the last match written is therefore the first set bit
  // after i_last in round-robin order.
  always_comb begin
    o_hit = 1'b0;
    o_idx = '0;
    w_pos = '0;
    for (int k = N; k >= 1; k--) begin
      w_pos = IW'((int'(i_last) + k) % N);
      if (i_vec[w_pos]) begin
        o_hit = 1'b1;
        o_idx = w_pos;
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/hart_mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : hart_mem_arbiter
// Description : Latches one-cycle load/store pulses from each hart into a
//               per-hart slot and serialises them onto the single DRAM port
//               with round-robin arbitration.
// Ports       : CLK, RST_X          - clock, asynchronous active-low reset
//               w_hart_le/we        - per-hart load/store request pulses
//               w_hart_addr/wdata   - per-hart address and store data
//               w_hart_ctrl         - per-hart size/sign control
//               w_hart_busy/odata   - per-hart busy flag and read data
//               w_grant             - id of the hart owning the DRAM port
//               w_dram_*            - DRAM controller request/response port
// Revision    : 1.0 - initial release
// ============================================================================
module hart_mem_arbiter
  import hart_mem_arbiter_pkg::*;
#(
  parameter int NHART = NHART_DEFAULT,
  parameter int AW    = 32
) (
  input  logic                    CLK,
  input  logic                    RST_X,
  input  logic [NHART-1:0]        w_hart_le,
  input  logic [NHART-1:0]        w_hart_we,
  input  logic [NHART*AW-1:0]     w_hart_addr,
  input  logic [NHART*AW-1:0]     w_hart_wdata,
  input  logic [NHART*CTRL_W-1:0] w_hart_ctrl,
  output logic [NHART-1:0]        w_hart_busy,
  output logic [NHART*AW-1:0]     w_hart_odata,
  output logic [31:0]             w_grant,
  output logic [AW-1:0]           w_dram_addr,
  output logic [AW-1:0]           w_dram_wdata,
  output logic [CTRL_W-1:0]       w_dram_ctrl,
  output logic                    w_dram_le,
  output logic                    w_dram_we,
  input  logic [AW-1:0]           w_dram_odata,
  input  logic                    w_dram_busy
);

  localparam int IW = $clog2(NHART);

  arb_state_e         state_q, state_d;
  logic               wait_first_q, wait_first_d;
  logic [IW-1:0]      grant_q, grant_d;
  logic [IW-1:0]      last_q, last_d;
  logic [NHART-1:0]   pend_q, pend_d;
  logic [NHART-1:0]   slot_we_q, slot_we_d;
  logic [AW-1:0]      slot_addr_q  [NHART];
  logic [AW-1:0]      slot_addr_d  [NHART];
  logic [AW-1:0]      slot_wdata_q [NHART];
  logic [AW-1:0]      slot_wdata_d [NHART];
  logic [CTRL_W-1:0]  slot_ctrl_q  [NHART];
  logic [CTRL_W-1:0]  slot_ctrl_d  [NHART];
  logic [AW-1:0]      odata_q      [NHART];
  logic [AW-1:0]      odata_d      [NHART];
  logic [AW-1:0]      dram_addr_q, dram_addr_d;
  logic [AW-1:0]      dram_wdata_q, dram_wdata_d;
  logic [CTRL_W-1:0]  dram_ctrl_q, dram_ctrl_d;
  logic               dram_le_q, dram_le_d;
  logic               dram_we_q, dram_we_d;

  logic [NHART-1:0]   w_req;
  logic [IW-1:0]      w_pick_idx;
  logic               w_pick_hit;
  logic               w_sel_we;

  assign w_req = w_hart_le | w_hart_we;

  // Live pulses compete in the same cycle they arrive so an idle bus issues
  // the strobe one cycle after the pulse.
  hart_mem_arbiter_rr_pick #(
    .N  (NHART),
    .IW (IW)
  ) u_pick (
    .i_vec  (pend_q | w_req),
    .i_last (last_q),
    .o_idx  (w_pick_idx),
    .o_hit  (w_pick_hit)
  );

  always_comb begin
    state_d      = state_q;
    wait_first_d = 1'b0;
    grant_d      = grant_q;
    last_d       = last_q;
    pend_d       = pend_q;
    slot_we_d    = slot_we_q;
    slot_addr_d  = slot_addr_q;
    slot_wdata_d = slot_wdata_q;
    slot_ctrl_d  = slot_ctrl_q;
    odata_d      = odata_q;
    dram_addr_d  = dram_addr_q;
    dram_wdata_d = dram_wdata_q;
    dram_ctrl_d  = dram_ctrl_q;
    dram_le_d    = 1'b0;
    dram_we_d    = 1'b0;
    w_sel_we     = 1'b0;

    // Capture new requests; a pulse on an already pending hart is dropped.
    for (int i = 0; i < NHART; i++) begin
      if (w_req[i] && !pend_q[i]) begin
        pend_d[i]       = 1'b1;
        slot_we_d[i]    = w_hart_we[i];
        slot_addr_d[i]  = w_hart_addr[i*AW +: AW];
        slot_wdata_d[i] = w_hart_wdata[i*AW +: AW];
        slot_ctrl_d[i]  = w_hart_ctrl[i*CTRL_W +: CTRL_W];
      end
    end

    case (state_q)
      ARB_IDLE: begin
        if (w_pick_hit) begin
          if (pend_q[w_pick_idx]) begin
            w_sel_we     = slot_we_q[w_pick_idx];
            dram_addr_d  = slot_addr_q[w_pick_idx];
            dram_wdata_d = slot_wdata_q[w_pick_idx];
            dram_ctrl_d  = slot_ctrl_q[w_pick_idx];
          end else begin
            w_sel_we     = w_hart_we[w_pick_idx];
            dram_addr_d  = w_hart_addr[int'(w_pick_idx)*AW +: AW];
            dram_wdata_d = w_hart_wdata[int'(w_pick_idx)*AW +: AW];
            dram_ctrl_d  = w_hart_ctrl[int'(w_pick_idx)*CTRL_W +: CTRL_W];
          end
          // Strobes are registered here so they are high exactly in ISSUE.
          dram_le_d = !w_sel_we;
          dram_we_d = w_sel_we;
          grant_d   = w_pick_idx;
          last_d    = w_pick_idx;
          state_d   = ARB_ISSUE;
        end
      end
      ARB_ISSUE: begin
        wait_first_d = 1'b1;
        state_d      = ARB_WAIT;
      end
      ARB_WAIT: begin
        // The controller may not have raised busy yet in the first cycle.
        if (!wait_first_q && !w_dram_busy) begin
          if (!slot_we_q[grant_q]) begin
            odata_d[grant_q] = w_dram_odata;
          end
          pend_d[grant_q] = 1'b0;
          state_d         = ARB_IDLE;
        end
      end
      default: state_d = ARB_IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge RST_X) begin
    if (!RST_X) begin
      state_q      <= ARB_IDLE;
      wait_first_q <= 1'b0;
      grant_q      <= '0;
      last_q       <= IW'(NHART - 1);
      pend_q       <= '0;
      slot_we_q    <= '0;
      for (int i = 0; i < NHART; i++) begin
        slot_addr_q[i]  <= '0;
        slot_wdata_q[i] <= '0;
        slot_ctrl_q[i]  <= '0;
        odata_q[i]      <= '0;
      end
      dram_addr_q  <= '0;
      dram_wdata_q <= '0;
      dram_ctrl_q  <= '0;
      dram_le_q    <= 1'b0;
      dram_we_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      wait_first_q <= wait_first_d;
      grant_q      <= grant_d;
      last_q       <= last_d;
      pend_q       <= pend_d;
      slot_we_q    <= slot_we_d;
      slot_addr_q  <= slot_addr_d;
      slot_wdata_q <= slot_wdata_d;
      slot_ctrl_q  <= slot_ctrl_d;
      odata_q      <= odata_d;
      dram_addr_q  <= dram_addr_d;
      dram_wdata_q <= dram_wdata_d;
      dram_ctrl_q  <= dram_ctrl_d;
      dram_le_q    <= dram_le_d;
      dram_we_q    <= dram_we_d;
    end
  end

`ifdef SIM_MODE
  always @(posedge CLK) begin
    for (int i = 0; i < NHART; i++) begin
      if (RST_X && w_req[i] && pend_q[i]) begin
        $display("hart_mem_arbiter: protocol error, hart %0d pulsed while pending; request ignored", i);
      end
    end
  end
`endif

  // Busy rises combinationally with the pulse so the hart stalls at once.
  assign w_hart_busy  = pend_q | w_req;
  assign w_grant      = 32'(grant_q);
  assign w_dram_addr  = dram_addr_q;
  assign w_dram_wdata = dram_wdata_q;
  assign w_dram_ctrl  = dram_ctrl_q;
  assign w_dram_le    = dram_le_q;
  assign w_dram_we    = dram_we_q;

  for (genvar gi = 0; gi < NHART; gi++) begin : g_odata
    assign w_hart_odata[gi*AW +: AW] = odata_q[gi];
  end

endmodule
`default_nettype wire
